uart_pkt_scheduler: RTL and testbench
=====================================

# uart_pkt_scheduler

Read-side controller for the UART async FIFO. It drains bytes from the FIFO read port and buffers up to MAX_PAYLOAD of them. It then emits a framed packet (SOF, LEN, payload, optional checksum) to the UART transmitter over a valid/ready byte interface. It runs entirely in the FIFO read-clock domain and is the only agent driving the FIFO `read_en`.

## Interface
- MAX_PAYLOAD, 16: payload bytes per packet, 1..255.
- IDLE_TIMEOUT, 8: empty-FIFO cycles after the last received byte that close a partial packet, ≥1.
- SOF_BYTE, 8'hA5: start-of-frame byte.
- clk  in  1  FIFO read clock.
- rst_n  in  1  asynchronous, active-low reset.
- fifo_empty  in  1  FIFO `empty`.
- fifo_data  in  8  FIFO `data_out`.
- fifo_data_valid  in  1  FIFO `data_valid`, one-cycle pulse.
- fifo_rd_en  out  1  FIFO `read_en`, combinational.
- tx_data  out  8  byte to UART TX.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  UART TX accepts byte.
- busy  out  1  high in any state other than IDLE.
- pkt_done  out  1  one-cycle pulse after the last byte of a packet is accepted.

## Operation
- States:
  - IDLE
  - FETCH
  - SEND_SOF
  - SEND_LEN
  - SEND_PAY
  - SEND_CHK (checksum build only)
- `fifo_rd_en` = (state ∈ {IDLE, FETCH}) & !fifo_empty & !rd_pending & (cnt < MAX_PAYLOAD).
  - `rd_pending` sets on `fifo_rd_en` and clears on `fifo_data_valid`, so at most one read is outstanding.
- IDLE → FETCH in the same cycle `fifo_rd_en` is asserted.
- FETCH:
  - On `fifo_data_valid`: buf[cnt] ← fifo_data, cnt++, tmo ← 0, chk ^= fifo_data.
  - When fifo_empty & !rd_pending: tmo++.
  - Exit to SEND_SOF when cnt == MAX_PAYLOAD (after the storing edge), or when tmo == IDLE_TIMEOUT.
- SEND_SOF → SEND_LEN → SEND_PAY.
  - Each state advances on a tx_valid & tx_ready handshake.
  - tx_data = SOF_BYTE, then cnt, then buf[0..cnt-1].
- SEND_PAY ends after byte cnt-1 is accepted. The next state is SEND_CHK, or IDLE when checksum is compiled out.
- SEND_CHK sends chk ^ cnt (LEN), then goes to IDLE.
- On entering IDLE: pkt_done pulses, and cnt, chk and idx clear.
- No FIFO reads occur in any SEND_* state; the FIFO absorbs incoming data meanwhile.
- Widths:
  - cnt and idx: $clog2(MAX_PAYLOAD+1).
  - tmo: $clog2(IDLE_TIMEOUT+1), saturating.
  - chk: 8 bits.
- `tx_valid` is high in every SEND_* state. `tx_data` holds stable while tx_valid & !tx_ready.
- `fifo_data_valid` arriving outside FETCH is impossible by construction. If it occurs anyway, it is ignored.

## Timing
- Reset (async assert) drives every output to 0. State goes to IDLE; cnt, idx, tmo, chk and rd_pending go to 0. A partial packet is dropped, and tx_valid falls immediately.
- Read latency: fifo_rd_en at edge N gives fifo_data_valid at N+1. Maximum fetch rate is 1 byte per 2 cycles.
- SEND_SOF is entered on the clock edge that closes the packet. tx_valid is high from the next cycle.
- With tx_ready held high, each packet byte takes 1 cycle. pkt_done is high in the cycle after the final handshake.
- A packet is never sent with cnt == 0. FETCH is only entered after a read has been issued.

## Configuration
- `PKT_CHECKSUM_EN` defined:
  - SEND_CHK is present and the frame is SOF, LEN, N payload bytes, CHK.
  - CHK = LEN XOR all payload bytes.
- `PKT_CHECKSUM_EN` undefined:
  - SEND_CHK and the chk register are removed; the frame is SOF, LEN, payload.
  - pkt_done follows the last payload byte.

## Structure
- Package `uart_pkt_pkg` holds:
  - the state enum type;
  - the default SOF_BYTE constant;
  - the LEN/CHK field width localparam (8).
- Sub-module `pkt_payload_buf` is a MAX_PAYLOAD×8 register array with one synchronous write port (addr, data, we) and one combinational read port (addr). It has no reset on its contents.

## Test plan
- Write 11,22,33 then stay idle (IDLE_TIMEOUT=8, tx_ready=1, checksum on) → tx stream A5,03,11,22,33,03; one pkt_done.
- Write 20 bytes back-to-back (MAX_PAYLOAD=16) → packet LEN=10h with 16 payload bytes, then after timeout a packet LEN=04h with bytes 17–20; no byte lost or duplicated.
- Hold tx_ready low for 5 cycles mid-payload → tx_data and tx_valid held constant; fifo_rd_en stays 0 throughout SEND_*.
- Bytes spaced 6 cycles apart (gap < IDLE_TIMEOUT) → a single packet containing all bytes; with a 12-cycle gap → two packets.
- Assert rst_n=0 during SEND_PAY → tx_valid, busy, fifo_rd_en go to 0 asynchronously. After release, the next FIFO bytes start a new frame at A5.
- Build without PKT_CHECKSUM_EN, stimulus as in the first scenario → A5,03,11,22,33; pkt_done one cycle after 33 is accepted.

Source files
------------

// File: rtl/uart_pkt_pkg.sv
// rtl/uart_pkt_pkg.sv - shared types and constants for the UART packet scheduler
//
// Contents: scheduler state enum, default start-of-frame byte, LEN/CHK field width.
package uart_pkt_pkg;

    localparam int LEN_W = 8;

    localparam logic [LEN_W-1:0] SOF_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND_SOF,
        ST_SEND_LEN,
        ST_SEND_PAY,
        ST_SEND_CHK
    } pkt_state_t;

endpackage

// File: rtl/uart_pkt_scheduler_if.sv
// rtl/uart_pkt_scheduler_if.sv - valid/ready byte stream from scheduler to UART TX
//
// Signals: tx_data (byte), tx_valid (byte valid), tx_ready (sink accepts byte).
// master: scheduler side (drives tx_data/tx_valid); slave: UART TX side (drives tx_ready).
interface uart_pkt_scheduler_if;
    import uart_pkt_pkg::*;

    logic [LEN_W-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/pkt_payload_buf.sv
// rtl/pkt_payload_buf.sv - payload byte store, one sync write port, one comb read port
//
// Ports: clk, we/waddr/wdata (write on rising clk), raddr -> rdata (combinational).
// Contents are not reset. Depth is 2**AW; entries beyond the payload limit stay unused.
module pkt_payload_buf #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_pkt_scheduler.sv
// rtl/uart_pkt_scheduler.sv - drains the UART FIFO and frames bytes into SOF/LEN/payload[/CHK] packets
//
// Optional feature macro: PKT_CHECKSUM_EN (adds trailing CHK = LEN ^ payload bytes).
// Ports:
//   clk, rst_n          FIFO read clock, asynchronous active-low reset
//   fifo_empty          FIFO empty flag
//   fifo_data           FIFO read data, qualified by fifo_data_valid (one-cycle pulse)
//   fifo_rd_en          FIFO read enable (combinational)
//   tx                  byte stream to UART TX (master modport)
//   busy                high whenever not idle
//   pkt_done            one-cycle pulse after the final byte of a packet is accepted
module uart_pkt_scheduler
    import uart_pkt_pkg::*;
#(
    parameter int               MAX_PAYLOAD  = 16,
    parameter int               IDLE_TIMEOUT = 8,
    parameter logic [LEN_W-1:0] SOF_BYTE     = SOF_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [7:0]            fifo_data,
    input  logic                  fifo_data_valid,
    output logic                  fifo_rd_en,
    uart_pkt_scheduler_if.master  tx,
    output logic                  busy,
    output logic                  pkt_done
);

    localparam int CW = $clog2(MAX_PAYLOAD + 1);
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);
    localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_PAYLOAD);
    localparam logic [TW-1:0] TMO_MAX  = TW'(IDLE_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(IDLE_TIMEOUT - 1);

    pkt_state_t    state, state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] idx;
    logic [TW-1:0] tmo;
    logic          rd_pending;
    logic          pkt_done_r;
    logic [7:0]    buf_rdata;

    logic store;
    logic tmo_inc;
    logic hs;
    logic last_pay;
    logic close_full;
    logic close_tmo;
    logic pkt_end;

`ifdef PKT_CHECKSUM_EN
    logic [7:0] chk;
`endif

    // Reads only while collecting, one outstanding at a time. Gating with rst_n
    // keeps the enable low for the whole time reset is held.
    assign fifo_rd_en = rst_n && ((state == ST_IDLE) || (state == ST_FETCH)) &&
                        !fifo_empty && !rd_pending && (cnt < CNT_MAX);

    assign store    = (state == ST_FETCH) && fifo_data_valid;
    assign tmo_inc  = (state == ST_FETCH) && fifo_empty && !rd_pending;
    assign hs       = tx.tx_valid && tx.tx_ready;
    assign last_pay = (idx == cnt - CW'(1));

    // Close on the edge that stores the final byte or that would bring tmo to
    // IDLE_TIMEOUT; in both cycles no read can be issued, so nothing is in flight
    // when the packet leaves FETCH.
    assign close_full = store && (cnt == CNT_MAX - CW'(1));
    assign close_tmo  = tmo_inc && (tmo == TMO_LAST) && (cnt != '0);

`ifdef PKT_CHECKSUM_EN
    assign pkt_end = hs && (state == ST_SEND_CHK);
`else
    assign pkt_end = hs && (state == ST_SEND_PAY) && last_pay;
`endif

    pkt_payload_buf #(.AW(AW)) u_buf (
        .clk   (clk),
        .we    (store),
        .waddr (cnt[AW-1:0]),
        .wdata (fifo_data),
        .raddr (idx[AW-1:0]),
        .rdata (buf_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        tx.tx_valid = 1'b0;
        tx.tx_data  = '0;
        unique case (state)
            ST_IDLE: begin
                if (fifo_rd_en) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (close_full || close_tmo) state_nxt = ST_SEND_SOF;
            end
            ST_SEND_SOF: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = SOF_BYTE;
                if (hs) state_nxt = ST_SEND_LEN;
            end
            ST_SEND_LEN: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = LEN_W'(cnt);
                if (hs) state_nxt = ST_SEND_PAY;
            end
            ST_SEND_PAY: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = buf_rdata;
                if (hs && last_pay) begin
`ifdef PKT_CHECKSUM_EN
                    state_nxt = ST_SEND_CHK;
`else
                    state_nxt = ST_IDLE;
`endif
                end
            end
            ST_SEND_CHK: begin
`ifdef PKT_CHECKSUM_EN
                tx.tx_valid = 1'b1;
                tx.tx_data  = chk ^ LEN_W'(cnt);
                if (hs) state_nxt = ST_IDLE;
`else
                state_nxt = ST_IDLE;
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            tmo        <= '0;
            rd_pending <= 1'b0;
            pkt_done_r <= 1'b0;
        end else begin
            pkt_done_r <= pkt_end;

            if (fifo_rd_en) begin
                rd_pending <= 1'b1;
            end else if (fifo_data_valid) begin
                rd_pending <= 1'b0;
            end

            if (pkt_end) begin
                cnt <= '0;
                idx <= '0;
            end else begin
                if (store) cnt <= cnt + CW'(1);
                if (hs && (state == ST_SEND_PAY) && !last_pay) idx <= idx + CW'(1);
            end

            if (state != ST_FETCH || store) begin
                tmo <= '0;
            end else if (tmo_inc && (tmo != TMO_MAX)) begin
                tmo <= tmo + TW'(1);
            end
        end
    end

`ifdef PKT_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk <= '0;
        end else if (pkt_end) begin
            chk <= '0;
        end else if (store) begin
            chk <= chk ^ fifo_data;
        end
    end
`endif

    assign busy     = (state != ST_IDLE);
    assign pkt_done = pkt_done_r;

endmodule

// File: tb/tb_uart_pkt_scheduler.sv
// tb/tb_uart_pkt_scheduler.sv - self-checking bench for uart_pkt_scheduler
module tb_uart_pkt_scheduler;
    import uart_pkt_pkg::*;

    localparam int MAXP = 16;
    localparam int TMO  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fifo_empty = 1'b0;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_data_valid = 1'b0;
    logic       fifo_rd_en;
    logic       busy;
    logic       pkt_done;

    uart_pkt_scheduler_if tx_if ();

    uart_pkt_scheduler #(
        .MAX_PAYLOAD  (MAXP),
        .IDLE_TIMEOUT (TMO),
        .SOF_BYTE     (8'hA5)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fifo_empty      (fifo_empty),
        .fifo_data       (fifo_data),
        .fifo_data_valid (fifo_data_valid),
        .fifo_rd_en      (fifo_rd_en),
        .tx              (tx_if.master),
        .busy            (busy),
        .pkt_done        (pkt_done)
    );

    always #5 clk = ~clk;

    // kind: 0 SOF, 1 LEN, 2 payload, 3 CHK
    typedef struct {
        logic [7:0] data;
        int         kind;
        bit         last;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fifo_q[$];
    logic [7:0] cap_q[$];
    logic [7:0] len_seen[$];

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int stall_seen = 0;
    int stall_req = 0;
    bit rdy_rand = 1'b0;
    bit rd_seen = 1'b0;

    bit         done_pend = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    exp_t       mon_e;

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void push_exp(input logic [7:0] d, input int k, input bit l);
        exp_t e;
        e.data = d;
        e.kind = k;
        e.last = l;
        exp_q.push_back(e);
    endfunction

    // Reference framing: a group of closely spaced bytes becomes consecutive
    // packets of at most MAXP payload bytes each, in arrival order.
    task automatic model_group(input logic [7:0] b[$]);
        int pos;
        pos = 0;
        while (pos < b.size()) begin
            int n;
            logic [7:0] x;
            n = (b.size() - pos > MAXP) ? MAXP : b.size() - pos;
            x = 8'(n);
            push_exp(8'hA5, 0, 1'b0);
            push_exp(8'(n), 1, 1'b0);
            for (int i = 0; i < n; i++) begin
                x = x ^ b[pos + i];
`ifdef PKT_CHECKSUM_EN
                push_exp(b[pos + i], 2, 1'b0);
`else
                push_exp(b[pos + i], 2, (i == n - 1));
`endif
            end
`ifdef PKT_CHECKSUM_EN
            push_exp(x, 3, 1'b1);
`endif
            pos += n;
        end
    endtask

    task automatic write_group(input logic [7:0] b[$], input int gap);
        model_group(b);
        foreach (b[i]) begin
            @(posedge clk);
            #2;
            fifo_q.push_back(b[i]);
            fifo_empty = 1'b0;
            repeat (gap - 1) @(posedge clk);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy || fifo_q.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk_eq("drain_in_time", (t < 3000), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_payload();
        int t;
        t = 0;
        while (!(tx_if.tx_valid && exp_q.size() > 0 && exp_q[0].kind == 2) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk_eq("payload_reached", (t < 1000), 1);
    endtask

    task automatic rand_group(input int n, output logic [7:0] b[$]);
        b = {};
        for (int i = 0; i < n; i++) b.push_back(8'($urandom_range(255)));
    endtask

    // FIFO read port and TX sink
    initial begin
        tx_if.tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            rd_seen = fifo_rd_en;
            @(posedge clk);
            #1;
            if (rd_seen) chk_eq("read_not_empty", (fifo_q.size() > 0), 1);
            if (rd_seen && fifo_q.size() > 0) begin
                fifo_data       = fifo_q.pop_front();
                fifo_data_valid = 1'b1;
            end else begin
                fifo_data_valid = 1'b0;
            end
            fifo_empty = (fifo_q.size() == 0);
            if (stall_req > 0) begin
                tx_if.tx_ready = 1'b0;
                stall_req--;
            end else begin
                tx_if.tx_ready = rdy_rand ? ($urandom_range(3) != 0) : 1'b1;
            end
        end
    end

    // Compare process
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done_pend  = 1'b0;
                prev_stall = 1'b0;
                continue;
            end
            chk_eq("pkt_done", pkt_done, done_pend);
            if (pkt_done) done_cnt++;
            done_pend = 1'b0;
            if (tx_if.tx_valid) begin
                chk_eq("no_read_in_send", fifo_rd_en, 0);
                chk_eq("busy_in_send", busy, 1);
            end
            if (prev_stall) begin
                chk_eq("stall_valid_held", tx_if.tx_valid, 1);
                chk_eq("stall_data_held", tx_if.tx_data, prev_data);
            end
            if (tx_if.tx_valid && !tx_if.tx_ready) stall_seen++;
            prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
            prev_data  = tx_if.tx_data;
            if (tx_if.tx_valid && tx_if.tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: actual=%0h required=none", tx_if.tx_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk_eq("tx_data", tx_if.tx_data, mon_e.data);
                    cap_q.push_back(tx_if.tx_data);
                    if (mon_e.kind == 1) len_seen.push_back(tx_if.tx_data);
                    done_pend = mon_e.last;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b[$];
        logic [7:0] lit[$];

        // Reset state (FIFO shows data so the read-enable check means something)
        #3;
        chk_eq("rst_tx_valid", tx_if.tx_valid, 0);
        chk_eq("rst_tx_data", tx_if.tx_data, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_pkt_done", pkt_done, 0);
        chk_eq("rst_rd_en", fifo_rd_en, 0);
        #20;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Three bytes then idle
        cap_q.delete();
        done_cnt = 0;
        b = '{8'h11, 8'h22, 8'h33};
        write_group(b, 1);
        wait_drain();
        lit = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33};
`ifdef PKT_CHECKSUM_EN
        lit.push_back(8'h03);
`endif
        chk_eq("s1_stream_len", cap_q.size(), lit.size());
        foreach (lit[i]) begin
            if (i < cap_q.size()) chk_eq("s1_stream_byte", cap_q[i], lit[i]);
        end
        chk_eq("s1_pkt_done_count", done_cnt, 1);

        // 20 bytes back to back: full packet then timeout packet
        len_seen.delete();
        b = {};
        for (int i = 1; i <= 20; i++) b.push_back(8'(i));
        write_group(b, 1);
        wait_drain();
        chk_eq("s2_pkt_count", len_seen.size(), 2);
        if (len_seen.size() == 2) begin
            chk_eq("s2_len0", len_seen[0], 8'h10);
            chk_eq("s2_len1", len_seen[1], 8'h04);
        end

        // Five-cycle stall mid-payload
        rand_group(20, b);
        write_group(b, 1);
        wait_payload();
        stall_seen = 0;
        stall_req = 5;
        wait_drain();
        chk_eq("s3_stall_cycles", stall_seen, 5);

        // Bytes 6 cycles apart join into one packet
        done_cnt = 0;
        rand_group(5, b);
        write_group(b, 6);
        wait_drain();
        chk_eq("s4_gap6_packets", done_cnt, 1);

        // Bytes 12 cycles apart become separate packets
        done_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            rand_group(1, b);
            write_group(b, 1);
            repeat (11) @(posedge clk);
        end
        wait_drain();
        chk_eq("s4_gap12_packets", done_cnt, 3);

        // Asynchronous reset during payload
        rand_group(20, b);
        write_group(b, 1);
        wait_payload();
        stall_req = 4;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("arst_tx_valid", tx_if.tx_valid, 0);
        chk_eq("arst_busy", busy, 0);
        chk_eq("arst_rd_en", fifo_rd_en, 0);
        chk_eq("arst_pkt_done", pkt_done, 0);
        exp_q.delete();
        fifo_q.delete();
        stall_req = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cap_q.delete();
        b = '{8'h5A, 8'hC3, 8'h0F};
        write_group(b, 1);
        wait_drain();
        chk_eq("post_rst_sof", (cap_q.size() > 0) ? cap_q[0] : 8'h00, 8'hA5);
        chk_eq("post_rst_len", (cap_q.size() > 1) ? cap_q[1] : 8'h00, 8'h03);

        // Randomized groups with random sink back-pressure
        rdy_rand = 1'b1;
        for (int g = 0; g < 8; g++) begin
            rand_group($urandom_range(1, 40), b);
            write_group(b, $urandom_range(1, 6));
            wait_drain();
        end
        rdy_rand = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
